// File: rtl/mem_stream_pkg.sv
// rtl/mem_stream_pkg.sv - shared types for the memory stream reader
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry FIFO buffering read data toward the output stream
module stream_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry [2];
    logic             rd_ptr;
    logic             wr_ptr;

    assign head = entry[rd_ptr];

    // Callers never push when full without popping, nor pop when empty.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            entry[0] <= '0;
            entry[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - burst reader streaming memory words; MEM_STREAM_READER_WRAP_EN enables address wrap
module mem_stream_reader #(
    parameter  int WIDTH  = 16,
    parameter  int HEIGHT = 16,
    localparam int AW     = $clog2(HEIGHT),
    localparam int LW     = $clog2(HEIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LW-1:0]    length,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    mem_read_addr,
    output logic             mem_read_en,
    input  logic [WIDTH-1:0] mem_qout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    import mem_stream_pkg::*;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic [LW-1:0] remaining;
    logic          err_q;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic          legal;
    logic          accept;
    logic [LW:0]   end_addr;

    assign end_addr = (LW+1)'(base_addr) + (LW+1)'(length);

    always_comb begin
        legal = (length <= LW'(HEIGHT)) && ((LW+1)'(base_addr) < (LW+1)'(HEIGHT));
`ifdef MEM_STREAM_READER_WRAP_EN
        legal = legal;
`else
        legal = legal && (end_addr <= (LW+1)'(HEIGHT));
`endif
    end

    assign accept    = (state == IDLE) && start && legal;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = (state == RUN) && (remaining != '0)
                       && ((count < 2'(FIFO_DEPTH)) || pop);

    assign mem_read_en   = push;
    assign mem_read_addr = addr;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign err           = err_q;

    // DONE is entered on the edge that drains the last word, so done follows the final pop directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if ((remaining == '0) && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (state == IDLE) && start && !legal;
            if (accept) begin
                addr      <= base_addr;
                remaining <= length;
            end else if (push) begin
                addr      <= (addr == AW'(HEIGHT - 1)) ? '0 : addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    stream_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_in   (rst_in),
        .push     (push),
        .push_data(mem_qout),
        .pop      (pop),
        .count    (count),
        .head     (out_data)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - self-checking bench for mem_stream_reader against a memory preloaded with i*3
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  length = '0;
    logic        busy, done, err;
    logic [3:0]  mem_read_addr;
    logic        mem_read_en;
    logic [15:0] mem_qout;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [15:0] mem_arr [16];

    int tests_run = 0;
    int failed = 0;

    int got[$];
    int raddr[$];
    int n_reads, first_valid, last_pop, done_cyc, done_cnt, err_cyc, err_cnt, busy_cnt, max_out, stall_bad;
    bit timed_out, hold_pending;
    logic [15:0] hold_data;

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) mem_arr[i] = 16'(i * 3);
    assign mem_qout = mem_arr[mem_read_addr];

    mem_stream_reader #(.WIDTH(16), .HEIGHT(16)) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_read_addr(mem_read_addr),
        .mem_read_en  (mem_read_en),
        .mem_qout     (mem_qout),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    function automatic bit wrap_enabled();
`ifdef MEM_STREAM_READER_WRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_legal(input int base, input int len);
        return (len <= 16) && (wrap_enabled() || (base + len <= 16));
    endfunction

    function automatic int model_word(input int base, input int i);
        return ((base + i) % 16) * 3;
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3 == 2);
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic observe(input int c);
        if (mem_read_en) begin
            raddr.push_back(int'(mem_read_addr));
            n_reads++;
        end
        if (busy) busy_cnt++;
        if (hold_pending && out_valid && (out_data !== hold_data)) stall_bad++;
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        if (out_valid && first_valid < 0) first_valid = c;
        if (out_valid && out_ready) begin
            got.push_back(int'(out_data));
            last_pop = c;
        end
        if (n_reads - got.size() > max_out) max_out = n_reads - got.size();
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
        end
        if (err) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = c;
        end
    endtask

    // Cycle 0 is the cycle in which start is high; inputs change on negedge and outputs are sampled 1 time unit later.
    task automatic run_burst(input int base, input int len, input int mode, input int restart_at);
        int end_at;
        end_at = -1;
        got.delete(); raddr.delete();
        n_reads = 0; first_valid = -1; last_pop = -1; done_cyc = -1; done_cnt = 0;
        err_cyc = -1; err_cnt = 0; busy_cnt = 0; max_out = 0; stall_bad = 0;
        timed_out = 1'b0; hold_pending = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 4'(base); length = 5'(len); out_ready = ready_for(mode, 0);
        #1 observe(0);
        for (int c = 1; c < 300; c++) begin
            @(negedge clk);
            start     = (c == restart_at);
            base_addr = 4'($urandom);
            length    = 5'($urandom_range(0, 16));
            out_ready = ready_for(mode, c);
            #1 observe(c);
            if (end_at < 0 && (done || err)) end_at = c + 2;
            if (c == end_at) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({busy, done, err, out_valid, mem_read_en} !== 5'b0) begin
            failed++;
            $display("FAIL reset_flags got=%b want=00000", {busy, done, err, out_valid, mem_read_en});
        end
        tests_run++;
        if (mem_read_addr !== 4'd0 || out_data !== 16'd0) begin
            failed++;
            $display("FAIL reset_data got addr=%0d data=%0d want 0/0", mem_read_addr, out_data);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_basic();
        int exp_w [4] = '{6, 9, 12, 15};
        run_burst(2, 4, 0, -1);
        tests_run++;
        if (got.size() !== 4) begin
            failed++;
            $display("FAIL basic_count got=%0d want=4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== exp_w[i]) begin
                failed++;
                $display("FAIL basic_word%0d got=%0d want=%0d", i, got[i], exp_w[i]);
            end
        end
        tests_run++;
        if (first_valid !== 2 || last_pop !== 5) begin
            failed++;
            $display("FAIL basic_timing got first=%0d last=%0d want 2/5", first_valid, last_pop);
        end
        tests_run++;
        if (done_cyc !== 6 || done_cnt !== 1 || timed_out) begin
            failed++;
            $display("FAIL basic_done got cyc=%0d cnt=%0d to=%0d want 6/1/0", done_cyc, done_cnt, timed_out);
        end
    endtask

    task automatic test_backpressure();
        run_burst(0, 5, 1, -1);
        tests_run++;
        if (got.size() !== 5) begin
            failed++;
            $display("FAIL bp_count got=%0d want=5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== i * 3) begin
                failed++;
                $display("FAIL bp_word%0d got=%0d want=%0d", i, got[i], i * 3);
            end
        end
        tests_run++;
        if (max_out !== 2 || n_reads !== 5) begin
            failed++;
            $display("FAIL bp_stall got outstanding=%0d reads=%0d want 2/5", max_out, n_reads);
        end
        tests_run++;
        if (stall_bad !== 0) begin
            failed++;
            $display("FAIL bp_hold got=%0d unstable cycles want=0", stall_bad);
        end
        tests_run++;
        if (done_cyc !== last_pop + 1 || done_cnt !== 1) begin
            failed++;
            $display("FAIL bp_done got cyc=%0d cnt=%0d want %0d/1", done_cyc, done_cnt, last_pop + 1);
        end
    endtask

    task automatic test_len0_and_illegal();
        run_burst(3, 0, 0, -1);
        tests_run++;
        if (n_reads !== 0 || done_cyc !== 2 || done_cnt !== 1 || busy_cnt !== 2) begin
            failed++;
            $display("FAIL len0 got reads=%0d done=%0d cnt=%0d busy=%0d want 0/2/1/2", n_reads, done_cyc, done_cnt, busy_cnt);
        end
        run_burst(0, 17, 0, -1);
        tests_run++;
        if (err_cyc !== 1 || err_cnt !== 1) begin
            failed++;
            $display("FAIL len17_err got cyc=%0d cnt=%0d want 1/1", err_cyc, err_cnt);
        end
        tests_run++;
        if (busy_cnt !== 0 || n_reads !== 0 || done_cnt !== 0) begin
            failed++;
            $display("FAIL len17_quiet got busy=%0d reads=%0d done=%0d want 0/0/0", busy_cnt, n_reads, done_cnt);
        end
    endtask

    task automatic test_wrap_edge();
        int exp_w [4] = '{42, 45, 0, 3};
        run_burst(14, 4, 0, -1);
        if (wrap_enabled()) begin
            tests_run++;
            if (got.size() !== 4 || done_cnt !== 1) begin
                failed++;
                $display("FAIL wrap_count got=%0d done=%0d want 4/1", got.size(), done_cnt);
            end
            for (int i = 0; i < 4 && i < got.size(); i++) begin
                tests_run++;
                if (got[i] !== exp_w[i]) begin
                    failed++;
                    $display("FAIL wrap_word%0d got=%0d want=%0d", i, got[i], exp_w[i]);
                end
            end
        end else begin
            tests_run++;
            if (err_cyc !== 1 || n_reads !== 0 || busy_cnt !== 0) begin
                failed++;
                $display("FAIL nowrap_err got err=%0d reads=%0d busy=%0d want 1/0/0", err_cyc, n_reads, busy_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pops;
        int dn;
        pops = 0;
        dn = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd0; length = 5'd6; out_ready = 1'b1;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1 if (out_valid && out_ready) pops++;
        end
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        tests_run++;
        if (pops !== 2) begin
            failed++;
            $display("FAIL rstmid_pops got=%0d want=2", pops);
        end
        tests_run++;
        if ({busy, done, err, out_valid, mem_read_en} !== 5'b0 || mem_read_addr !== 4'd0 || out_data !== 16'd0) begin
            failed++;
            $display("FAIL rstmid_outputs got flags=%b addr=%0d data=%0d want 0/0/0",
                     {busy, done, err, out_valid, mem_read_en}, mem_read_addr, out_data);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 if (done || busy) dn++;
        end
        tests_run++;
        if (dn !== 0) begin
            failed++;
            $display("FAIL rstmid_nodone got=%0d busy/done cycles want=0", dn);
        end
        run_burst(0, 1, 0, -1);
        tests_run++;
        if (got.size() != 1 || got[0] !== 0 || done_cnt !== 1) begin
            failed++;
            $display("FAIL rstmid_restart got n=%0d done=%0d want one word 0, done 1", got.size(), done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        run_burst(1, 6, 0, 3);
        tests_run++;
        if (got.size() !== 6 || n_reads !== 6 || done_cnt !== 1) begin
            failed++;
            $display("FAIL restart_count got n=%0d reads=%0d done=%0d want 6/6/1", got.size(), n_reads, done_cnt);
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== model_word(1, i)) begin
                failed++;
                $display("FAIL restart_word%0d got=%0d want=%0d", i, got[i], model_word(1, i));
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int base;
            int len;
            int bad;
            base = $urandom_range(0, 15);
            len  = $urandom_range(0, 17);
            run_burst(base, len, 2, -1);
            if (!model_legal(base, len)) begin
                tests_run++;
                if (err_cnt !== 1 || n_reads !== 0 || busy_cnt !== 0 || timed_out) begin
                    failed++;
                    $display("FAIL rand%0d_illegal base=%0d len=%0d got err=%0d reads=%0d busy=%0d", t, base, len, err_cnt, n_reads, busy_cnt);
                end
            end else begin
                bad = 0;
                for (int i = 0; i < len; i++) begin
                    if (i >= got.size() || got[i] !== model_word(base, i)) bad++;
                    if (i >= raddr.size() || raddr[i] !== (base + i) % 16) bad++;
                end
                tests_run++;
                if (bad !== 0 || got.size() !== len || n_reads !== len || timed_out) begin
                    failed++;
                    $display("FAIL rand%0d_data base=%0d len=%0d got words=%0d reads=%0d bad=%0d", t, base, len, got.size(), n_reads, bad);
                end
                tests_run++;
                if (done_cnt !== 1 || done_cyc !== ((len == 0) ? 2 : last_pop + 1) || max_out > 2 || stall_bad !== 0) begin
                    failed++;
                    $display("FAIL rand%0d_flow got done=%0d@%0d out=%0d hold=%0d want 1@%0d <=2 0", t, done_cnt, done_cyc, max_out, stall_bad,
                             (len == 0) ? 2 : last_pop + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len0_and_illegal();
        test_wrap_edge();
        test_reset_mid();
        test_restart_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning word width in bits, equal to the attached memory's WIDTH.
REQ-002 SHALL have parameter HEIGHT, default 16, meaning word count of the attached memory; AW = $clog2(HEIGHT), LW = $clog2(HEIGHT+1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; every flop is on posedge.
REQ-004 SHALL have port rst_in  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  meaning request a burst, sampled on posedge.
REQ-006 SHALL have port base_addr  input  AW  meaning first word address, captured with start.
REQ-007 SHALL have port length  input  LW  meaning word count, captured with start.
REQ-008 SHALL have port busy  output  1  meaning a burst is in progress.
REQ-009 SHALL have port done  output  1  meaning burst complete, a 1-cycle pulse.
REQ-010 SHALL have port err  output  1  meaning out-of-range request, a 1-cycle pulse.
REQ-011 SHALL have port mem_read_addr  output  AW  meaning memory read address.
REQ-012 SHALL have port mem_read_en  output  1  meaning memory read enable.
REQ-013 SHALL have port mem_qout  input  WIDTH  meaning memory read data, valid in the same cycle as the read (0-cycle memory).
REQ-014 SHALL have ports out_data (output, WIDTH), out_valid (output, 1) and out_ready (input, 1), meaning a valid/ready output stream.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE: IDLE->RUN on start with legal request; RUN->DONE when all words are read and the buffer has drained; DONE->IDLE unconditionally after 1 cycle.
REQ-016 SHALL assert busy in RUN and DONE; done SHALL be high only in DONE.
REQ-017 SHALL capture base_addr and length into a remaining-count and a current address on the start edge.
REQ-018 SHALL buffer read data in a 2-entry FIFO; a read SHALL be issued (mem_read_en=1) in RUN when remaining>0 and (count<2, or a pop occurs in the same cycle).
REQ-019 SHALL write mem_qout into the FIFO on the same edge on which the read was issued, then increment the address and decrement remaining.
REQ-020 SHALL present the FIFO head on out_data with out_valid=(count>0); a pop occurs on a cycle with out_valid && out_ready; a simultaneous push and pop SHALL leave count unchanged.
REQ-021 SHALL assert first out_valid 2 cycles after the start cycle; with out_ready held high, throughput SHALL be 1 word/cycle.
REQ-022 SHALL keep out_data stable while out_valid && !out_ready.
REQ-023 SHALL hold mem_read_addr at its last value and drive mem_read_en=0 when not reading; it SHALL never read beyond length words.
REQ-024 SHALL treat length=0 as a legal request: RUN->DONE with no reads, done pulsing 2 cycles after start.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL treat length>HEIGHT as illegal: err pulses 1 cycle later, state stays IDLE, no reads.

Reset
REQ-027 SHALL, on rst_in=1 at posedge, force IDLE, FIFO count 0, remaining 0, address 0, and all outputs low/zero (busy, done, err, out_valid, mem_read_en, mem_read_addr, out_data).
REQ-028 SHALL let reset mid-burst abort immediately, with no done pulse and buffered words discarded.

Configuration
REQ-029 SHALL use macro MEM_STREAM_READER_WRAP_EN: when defined, addresses wrap modulo HEIGHT (HEIGHT-1 -> 0) and base_addr+length>HEIGHT is legal.
REQ-030 SHALL, without MEM_STREAM_READER_WRAP_EN, treat base_addr+length>HEIGHT as illegal per REQ-026.

Structure
REQ-031 SHALL place the FSM state enum (IDLE/RUN/DONE) in shared package mem_stream_pkg.
REQ-032 SHALL implement the 2-entry buffer as sub-module stream_fifo2 (push, pop, count, head data).
REQ-033 SHALL connect mem_read_addr/mem_read_en/mem_qout directly to a memory instance's read_addr/read_en/qout.

Verification (WIDTH=16, HEIGHT=16, memory preloaded data[i]=i*3)
REQ-034 SHALL cover base=2, length=4, out_ready=1 -> out_data 6,9,12,15 on 4 consecutive cycles, first 2 cycles after start, done 1 cycle after last pop.
REQ-035 SHALL cover base=0, length=5, out_ready toggling 1,0,0,1,... -> words 0,3,6,9,12 in order, none lost or duplicated, reads stall when FIFO is full.
REQ-036 SHALL cover length=0 -> no mem_read_en, done 2 cycles after start; length=17 -> err pulse, busy stays 0.
REQ-037 SHALL cover base=14, length=4: with WRAP_EN -> 42,45,0,3; without -> err, no reads.
REQ-038 SHALL cover rst_in asserted after 2 of 6 words -> next cycle all outputs 0, no done; a new start with base=0, length=1 then returns 0.
REQ-039 SHALL cover start pulsed again mid-burst -> ignored, original burst completes unchanged.
